// File: rtl/uart_pkg.sv
// uart_pkg: UART timing constants, tx sequencer state encoding and the hex-ASCII
// helper used when UART_TX_HEX_ASCII_EN is defined.
package uart_pkg;
  localparam int CLK_FREQ = 133_000_000;
  localparam int UART_FREQ = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ / UART_FREQ;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
`ifdef UART_TX_HEX_ASCII_EN
    ,
    S_START2,
    S_BUSY2,
    S_DONE2
`endif
  } tx_state_t;
`ifdef UART_TX_HEX_ASCII_EN
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
`endif
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte circular buffer with registered full/empty/level flags.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  logic [ADDR_W:0] nxt_level;
  always_comb begin
    do_wr = wr_en && !full;
    do_rd = rd_en && !empty;
    nxt_level = level + {{ADDR_W{1'b0}}, do_wr} - {{ADDR_W{1'b0}}, do_rd};
    rd_data = mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  // flags are registered from the next count so they line up with level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + ADDR_W'(1) : rd_ptr;
      level <= nxt_level;
      full <= nxt_level == (ADDR_W+1)'(DEPTH);
      empty <= nxt_level == '0;
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus start/ready sequencer feeding the UART transmitter.
// UART_TX_HEX_ASCII_EN: send each byte as two upper-case hex ASCII characters.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              uart_ready,
  output logic              uart_start,
  output logic [7:0]        uart_data
);
  tx_state_t state, nxt;
  logic pop, in_busy, busy_cnt;
  logic [7:0] rd_data;
  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(pop),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  // busy_cnt bounds the wait for the UART to drop ready to two cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      busy_cnt <= 1'b0;
    end else begin
      state <= nxt;
      busy_cnt <= in_busy && !busy_cnt;
    end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = pop ? S_START : S_IDLE;
      S_START:  nxt = S_BUSY;
      S_BUSY:   nxt = !uart_ready ? S_DONE : busy_cnt ? S_IDLE : S_BUSY;
`ifdef UART_TX_HEX_ASCII_EN
      S_DONE:   nxt = uart_ready ? S_START2 : S_DONE;
      S_START2: nxt = S_BUSY2;
      S_BUSY2:  nxt = !uart_ready ? S_DONE2 : busy_cnt ? S_IDLE : S_BUSY2;
      S_DONE2:  nxt = uart_ready ? S_IDLE : S_DONE2;
`else
      S_DONE:   nxt = uart_ready ? S_IDLE : S_DONE;
`endif
      default:  nxt = S_IDLE;
    endcase
  end
  always_comb begin
    pop = state == S_IDLE && !empty && uart_ready;
`ifdef UART_TX_HEX_ASCII_EN
    uart_start = state == S_START || state == S_START2;
    in_busy = state == S_BUSY || state == S_BUSY2;
`else
    uart_start = state == S_START;
    in_busy = state == S_BUSY;
`endif
  end
`ifdef UART_TX_HEX_ASCII_EN
  logic [3:0] lo_nib;
  // high character is loaded at the pop, low character when the UART returns ready
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uart_data <= 8'h00;
      lo_nib <= 4'h0;
    end else if (pop) begin
      uart_data <= nib_to_ascii(rd_data[7:4]);
      lo_nib <= rd_data[3:0];
    end else if (state == S_DONE && uart_ready) begin
      uart_data <= nib_to_ascii(lo_nib);
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) uart_data <= 8'h00;
    else if (pop) uart_data <= rd_data;
`endif
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized self-checking bench with a behavioural UART and an expected-byte queue.
module tb_uart_tx_buffer;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, rst = 0, wr_en = 0, ovf_clr = 0, uart_ready;
  logic [7:0] wr_data = 0;
  logic full, empty, overflow, uart_start;
  logic [AW:0] level;
  logic [7:0] uart_data;
  int total = 0, bad = 0;
  logic [7:0] rx_q[$], exp_q[$];
  bit hold = 0;
  int busy_min = 2, busy_max = 6, busy;
  logic prev_start;

  uart_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .uart_ready(uart_ready), .uart_start(uart_start), .uart_data(uart_data)
  );

  always #5 clk = ~clk;

  // UART model: latches data on a start pulse, drops ready for a random time
  always @(posedge clk or posedge rst)
    if (rst) begin
      uart_ready <= 1;
      busy <= 0;
      prev_start <= 0;
    end else begin
      prev_start <= uart_start;
      if (uart_start) begin
        total++;
        if (prev_start === 1'b1) begin
          bad++;
          $display("FAIL start_two_cycles got=consecutive pulses exp=single pulse");
        end
        rx_q.push_back(uart_data);
        busy <= int'($urandom_range(busy_max, busy_min));
        uart_ready <= 0;
      end else if (busy != 0) busy <= busy - 1;
      else uart_ready <= !hold;
    end

  function automatic logic [7:0] hex_chr(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic void exp_push(input logic [7:0] b);
`ifdef UART_TX_HEX_ASCII_EN
    exp_q.push_back(hex_chr(int'(b) / 16));
    exp_q.push_back(hex_chr(int'(b) % 16));
`else
    exp_q.push_back(b);
`endif
  endfunction

  task automatic drain(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n && uart_ready && empty && busy == 0) begin
        ok = 1;
        break;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1;
    @(negedge clk);
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (uart_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", uart_start); end
    total++; if (uart_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", uart_data); end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    rx_q.delete(); exp_q.delete();
    exp_push(8'h55);
    wr_en = 1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 0;
    total++; if (uart_start !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", uart_start); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", empty); end
    @(negedge clk);
    total++; if (uart_start !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", uart_start); end
    total++; if (uart_data !== exp_q[0]) begin bad++; $display("FAIL single_data got=%h exp=%h", uart_data, exp_q[0]); end
    @(negedge clk);
    total++; if (uart_start !== 1'b0) begin bad++; $display("FAIL single_width got=%b exp=0", uart_start); end
    drain(exp_q.size(), ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_after got=%b exp=1", empty); end
  endtask

  task automatic test_burst;
    bit ok;
    rx_q.delete(); exp_q.delete();
    hold = 1;
    repeat (3) @(negedge clk);
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 1; wr_data = 8'(i);
      exp_push(8'(i));
      @(negedge clk);
    end
    wr_en = 0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full got=%b exp=1", full); end
    total++; if (level !== 5'(DEPTH)) begin bad++; $display("FAIL burst_level got=%0d exp=%0d", level, DEPTH); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_ovf got=%b exp=0", overflow); end
    hold = 0;
    drain(exp_q.size(), ok);
    total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL burst_order[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    int cnt = 0;
    logic [7:0] b;
    rx_q.delete(); exp_q.delete();
    hold = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      wr_en = 1; wr_data = b;
      if (cnt < DEPTH) begin exp_push(b); cnt++; end
      @(negedge clk);
      if (i == DEPTH - 1) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    wr_en = 0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (level !== 5'(DEPTH)) begin bad++; $display("FAIL ovf_level got=%0d exp=%0d", level, DEPTH); end
    @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    wr_en = 1; wr_data = 8'hEE; ovf_clr = 1;
    @(negedge clk);
    wr_en = 0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    @(negedge clk);
    ovf_clr = 0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    hold = 0;
    drain(exp_q.size(), ok);
    total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_simul;
    bit ok;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    rx_q.delete(); exp_q.delete();
    exp_push(a); exp_push(b);
    hold = 1;
    repeat (3) @(negedge clk);
    wr_en = 1; wr_data = a;
    @(negedge clk);
    wr_en = 0;
    total++; if (level !== 5'd1) begin bad++; $display("FAIL simul_pre_level got=%0d exp=1", level); end
    hold = 0;
    @(negedge clk);
    wr_en = 1; wr_data = b;
    @(negedge clk);
    wr_en = 0;
    total++; if (uart_start !== 1'b1) begin bad++; $display("FAIL simul_pop got=%b exp=1", uart_start); end
    total++; if (level !== 5'd1) begin bad++; $display("FAIL simul_level got=%0d exp=1", level); end
    drain(exp_q.size(), ok);
    total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL simul_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL simul_order[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b0;
    rx_q.delete(); exp_q.delete();
    busy_min = 25; busy_max = 25;
    b0 = 8'($urandom);
    exp_push(b0);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = (i == 0) ? b0 : 8'($urandom);
      @(negedge clk);
    end
    wr_en = 0;
    repeat (4) @(negedge clk);
    total++; if (level !== 5'd3) begin bad++; $display("FAIL rstmid_queued got=%0d exp=3", level); end
    #2 rst = 1;
    #1;
    total++; if (uart_start !== 1'b0) begin bad++; $display("FAIL rstmid_start got=%b exp=0", uart_start); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    total++; if (level !== '0) begin bad++; $display("FAIL rstmid_level got=%0d exp=0", level); end
    @(negedge clk);
    rst = 0;
    busy_min = 2; busy_max = 6;
    repeat (80) @(negedge clk);
    total++; if (rx_q.size() != 1) begin bad++; $display("FAIL rstmid_stale got=%0d exp=1", rx_q.size()); end
    total++; if (rx_q.size() > 0 && rx_q[0] !== exp_q[0]) begin bad++; $display("FAIL rstmid_first got=%h exp=%h", rx_q[0], exp_q[0]); end
  endtask

  task automatic test_random;
    bit ok;
    logic [7:0] b;
    for (int r = 0; r < 5; r++) begin
      rx_q.delete(); exp_q.delete();
      busy_min = int'($urandom_range(3, 1));
      busy_max = busy_min + int'($urandom_range(8, 0));
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) begin
        b = 8'($urandom);
        exp_push(b);
        wr_en = 1; wr_data = b;
        @(negedge clk);
        wr_en = 0;
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      drain(exp_q.size(), ok);
      total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_order[%0d] got=%h exp=%h", r, i, rx_q[i], exp_q[i]); end
      end
    end
    busy_min = 2; busy_max = 6;
  endtask

`ifdef UART_TX_HEX_ASCII_EN
  task automatic test_hex;
    bit ok;
    logic [7:0] want [4];
    want = '{8'h41, 8'h35, 8'h30, 8'h46};
    rx_q.delete(); exp_q.delete();
    wr_en = 1; wr_data = 8'hA5;
    @(negedge clk);
    wr_data = 8'h0F;
    @(negedge clk);
    wr_en = 0;
    drain(4, ok);
    total++; if (!ok || rx_q.size() != 4) begin bad++; $display("FAIL hex_count got=%0d exp=4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== want[i]) begin bad++; $display("FAIL hex_char[%0d] got=%h exp=%h", i, rx_q[i], want[i]); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_simul;
    test_reset_mid;
    test_random;
`ifdef UART_TX_HEX_ASCII_EN
    test_hex;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO plus transmit sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer (e.g. the HDR debug/pixel dump path) at full clock rate.
- Drains them one at a time into the UART using its start/data_in/ready handshake.
- Decouples the producer from the roughly 1155-clk-per-bit UART timing.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock (133 MHz domain)
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  producer write strobe
- wr_data  in  8  producer byte
- ovf_clr  in  1  clears the overflow flag
- full  out  1  FIFO full (count == DEPTH)
- empty  out  1  FIFO empty (count == 0)
- level  out  ADDR_W+1  current FIFO occupancy
- overflow  out  1  sticky flag: a write was dropped
- uart_ready  in  1  UART ready output
- uart_start  out  1  one-cycle start pulse to the UART
- uart_data  out  8  byte to the UART data_in

Behaviour:
- Reset (async, active-high): clears pointers, count and FSM (to S_IDLE); full=0, empty=1, level=0, overflow=0, uart_start=0, uart_data=8'h00. The UART is reset from the same source (inverted), so both blocks restart together. A byte in flight at reset is lost.
- FIFO: circular buffer with ADDR_W-bit pointers that wrap modulo DEPTH. full, empty and level are registered and derived from the count.
- Write acceptance: a write is accepted iff wr_en=1 and full=0 in that cycle. The pop decision in the same cycle does not make room; a write while full is dropped.
- Dropped write: sets overflow=1 on the next edge. overflow holds until ovf_clr=1. If ovf_clr and a dropped write occur in the same cycle, the set wins.
- Simultaneous write and pop: count is unchanged.
- FSM states:
  - S_IDLE: if empty=0 and uart_ready=1, pop the head byte into uart_data, drive uart_start=1 on the next cycle, and go to S_START. Otherwise stay.
  - S_START: uart_start is high for exactly this one cycle; go to S_BUSY.
  - S_BUSY: wait for uart_ready=0, which confirms the UART accepted the byte; then go to S_DONE. If uart_ready is still 1 after 2 cycles, return to S_IDLE without re-popping (protocol error; the byte is considered sent).
  - S_DONE: wait for uart_ready=1, then go to S_IDLE.
- uart_start is never high on two consecutive cycles. uart_data is stable from the pulse until the next pop.
- Latency: a write into an empty FIFO with the UART idle gives uart_start high 2 clk after the write edge (1 clk for the registered empty, 1 clk for the pop/registered start).
- Back-to-back bytes: the next pulse follows the UART returning ready, at most 2 clk after uart_ready rises.
- Order: bytes are transmitted strictly in write order. No byte is ever sent twice or skipped, except writes dropped on full.

Optional Feature:
- Macro: UART_TX_HEX_ASCII_EN.
- Defined: each popped byte is sent as two ASCII upper-case hex characters, high nibble first. Nibble 0-9 maps to 8'h30+n; nibble A-F maps to 8'h37+n.
  - Extra states S_START2/S_BUSY2/S_DONE2 send the low-nibble character; the byte is popped only once.
  - Example: 8'hA5 is sent as 8'h41 then 8'h35.
- Undefined: raw bytes are sent unchanged; the extra states and nibble logic are absent.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding;
  - the CLK_FREQ/UART_FREQ constants shared with the UART;
  - the nibble-to-ASCII function (used only when the macro is defined).
- One sub-module, sync_fifo (params DEPTH and ADDR_W; wr_en/wr_data/rd_en/rd_data/full/empty/level). The sequencer wraps it.

Test Plan:
- Single byte: write 8'h55 with the UART model idle → uart_start high exactly 2 clk later with uart_data=8'h55; one pulse only; empty=1 afterwards.
- Burst: write 8'h01..8'h10 on 16 consecutive cycles (DEPTH=16) → full=1, level=16, no overflow; the UART receives 01..10 in order, and 16 pulses each wait for uart_ready to rise.
- Overflow: with the UART held busy, write 17 bytes → byte 17 dropped, overflow=1 next clk; ovf_clr pulse → overflow=0; only 16 bytes are transmitted.
- Simultaneous write/pop: level=1, a write on the same cycle as the pop → level stays 1 and order is preserved.
- Reset mid-frame: assert rst while in S_DONE with 3 bytes queued → asynchronously uart_start=0, empty=1, level=0; after release no stale bytes are sent.
- Hex mode (UART_TX_HEX_ASCII_EN): write 8'hA5 then 8'h0F → the UART receives 8'h41, 8'h35, 8'h30, 8'h46.
